// File: rtl/rf_writeback_arbiter.sv
// Write-port front end of the 64-bit x 32 integer register file: merges pipeline and long-latency writebacks.
// Optional RF_WB_PENDING_EN adds read-address pending lookups (RD_ADDR1/2 -> PEND1/2).
module rf_writeback_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        P_VALID,
  input  logic [4:0]  P_ADDR,
  input  logic [63:0] P_DATA,
  input  logic        L_VALID,
  output logic        L_READY,
  input  logic [4:0]  L_ADDR,
  input  logic [63:0] L_DATA,
`ifdef RF_WB_PENDING_EN
  input  logic [4:0]  RD_ADDR1,
  input  logic [4:0]  RD_ADDR2,
  output logic        PEND1,
  output logic        PEND2,
`endif
  output logic        STALL,
  output logic        WE,
  output logic [4:0]  WR_ADDR,
  output logic [63:0] WR_DATA
);

  localparam int            AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [3:0]    LIMIT = 4'(STARVE_LIMIT);

  logic [4:0]    q_addr [DEPTH];
  logic [63:0]   q_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    starve;

  logic          we_q;
  logic [4:0]    addr_q;
  logic [63:0]   data_q;

  logic          pipe_wr;
  logic          accept;
  logic          push;
  logic          pop;
  logic          empty;

  assign empty   = (count == '0);
  // Readiness looks only at the registered count; a pop in the same cycle does not open a slot.
  assign L_READY = (count < FULL);
  assign pipe_wr = P_VALID && (P_ADDR != 5'd0);
  assign accept  = L_VALID && L_READY;
  assign push    = accept && (L_ADDR != 5'd0);
  assign pop     = !pipe_wr && !empty;

  always_ff @(posedge CLK) begin
    if (push) begin
      q_addr[wr_ptr] <= L_ADDR;
      q_data[wr_ptr] <= L_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + (AW+1)'(1);
      else if (pop && !push)
        count <= count - (AW+1)'(1);
    end
  end

  // Counts cycles in which queued results lose the port to the pipeline.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      starve <= 4'd0;
    end else if (pop || empty) begin
      starve <= 4'd0;
    end else if (pipe_wr && (starve != 4'hF)) begin
      starve <= starve + 4'd1;
    end
  end

  assign STALL = (starve >= LIMIT);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      we_q   <= 1'b0;
      addr_q <= 5'd0;
      data_q <= 64'd0;
    end else if (pipe_wr) begin
      we_q   <= 1'b1;
      addr_q <= P_ADDR;
      data_q <= P_DATA;
    end else if (pop) begin
      we_q   <= 1'b1;
      addr_q <= q_addr[rd_ptr];
      data_q <= q_data[rd_ptr];
    end else begin
      we_q   <= 1'b0;
    end
  end

  assign WE      = we_q;
  assign WR_ADDR = addr_q;
  assign WR_DATA = data_q;

`ifdef RF_WB_PENDING_EN
  // Per-slot occupancy lets the lookup scan the array without decoding the ring pointers.
  logic [DEPTH-1:0] slot_valid;
  logic             hit1;
  logic             hit2;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      slot_valid <= '0;
    end else begin
      if (pop)  slot_valid[rd_ptr] <= 1'b0;
      if (push) slot_valid[wr_ptr] <= 1'b1;
    end
  end

  always_comb begin
    hit1 = we_q && (addr_q == RD_ADDR1);
    hit2 = we_q && (addr_q == RD_ADDR2);
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && (q_addr[i] == RD_ADDR1)) hit1 = 1'b1;
      if (slot_valid[i] && (q_addr[i] == RD_ADDR2)) hit2 = 1'b1;
    end
  end

  assign PEND1 = (RD_ADDR1 != 5'd0) && hit1;
  assign PEND2 = (RD_ADDR2 != 5'd0) && hit2;
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: directed steps then random traffic against a queue-based model.
// Exercises RD_ADDR/PEND ports when RF_WB_PENDING_EN is defined.
module tb_rf_writeback_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        p_valid;
  logic [4:0]  p_addr;
  logic [63:0] p_data;
  logic        l_valid;
  logic        l_ready;
  logic [4:0]  l_addr;
  logic [63:0] l_data;
  logic        stall;
  logic        we;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
`ifdef RF_WB_PENDING_EN
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        pend1;
  logic        pend2;
`endif

  rf_writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .CLK(clk), .RESET(reset),
    .P_VALID(p_valid), .P_ADDR(p_addr), .P_DATA(p_data),
    .L_VALID(l_valid), .L_READY(l_ready), .L_ADDR(l_addr), .L_DATA(l_data),
`ifdef RF_WB_PENDING_EN
    .RD_ADDR1(rd_addr1), .RD_ADDR2(rd_addr2), .PEND1(pend1), .PEND2(pend2),
`endif
    .STALL(stall), .WE(we), .WR_ADDR(wr_addr), .WR_DATA(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
  } ent_t;

  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [63:0] m_data;
  int          m_starve;
  bit          m_rst;
  bit          acc_last;
  int          n_cmp;
  int          n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_pend(input logic [4:0] ra);
    if (ra == 5'd0) return 1'b0;
    if (m_we && m_addr == ra) return 1'b1;
    foreach (q[i]) if (q[i].a == ra) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the reference one clock using the inputs currently applied, then check the DUT.
  task automatic cycle();
    ent_t e;
    int   sz0;
    bit   pipe;
    bit   popped;
    pipe     = p_valid && (p_addr != 5'd0);
    sz0      = q.size();
    acc_last = l_valid && (sz0 < DEPTH) && !reset;
    popped   = 1'b0;
    m_rst    = reset;
    if (reset) begin
      q.delete();
      m_we = 1'b0; m_addr = 5'd0; m_data = 64'd0; m_starve = 0;
    end else begin
      if (pipe) begin
        m_we = 1'b1; m_addr = p_addr; m_data = p_data;
      end else if (sz0 > 0) begin
        e = q.pop_front();
        m_we = 1'b1; m_addr = e.a; m_data = e.d;
        popped = 1'b1;
      end else begin
        m_we = 1'b0;
      end
      if (sz0 == 0 || popped) m_starve = 0;
      else if (pipe && m_starve < 15) m_starve++;
      if (acc_last && l_addr != 5'd0) begin
        e.a = l_addr; e.d = l_data;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk("we", we, m_we);
    if (m_we || m_rst) begin
      chk("wr_addr", wr_addr, m_addr);
      chk("wr_data", wr_data, m_data);
    end
    chk("l_ready", l_ready, q.size() < DEPTH);
    chk("stall", stall, m_starve >= STARVE_LIMIT);
`ifdef RF_WB_PENDING_EN
    chk("pend1", pend1, exp_pend(rd_addr1));
    chk("pend2", pend2, exp_pend(rd_addr2));
`endif
  endtask

  task automatic offer(input logic [4:0] a);
    l_valid = 1'b1;
    l_addr  = a;
    l_data  = {$urandom, $urandom};
  endtask

  initial begin
    int seen[$];
    n_cmp = 0; n_err = 0;
    m_we = 1'b0; m_addr = '0; m_data = '0; m_starve = 0; m_rst = 1'b0; acc_last = 1'b0;
    reset = 1'b1; p_valid = 1'b0; p_addr = '0; p_data = '0;
    l_valid = 1'b0; l_addr = '0; l_data = '0;
`ifdef RF_WB_PENDING_EN
    rd_addr1 = '0; rd_addr2 = '0;
`endif
    #1;
    cycle();
    cycle();
    chk("rst_ready", l_ready, 1'b1);
    chk("rst_stall", stall, 1'b0);

    // single pipe write
    reset = 1'b0;
    p_valid = 1'b1; p_addr = 5'd5; p_data = 64'hDEAD_BEEF;
    cycle();
    chk("p5_we", we, 1'b1);
    chk("p5_addr", wr_addr, 5'd5);
    chk("p5_data", wr_data, 64'hDEAD_BEEF);
    p_valid = 1'b0;
    cycle();
    chk("p5_after", we, 1'b0);

    // idle pipe slot and discarded x0 transfer
    p_valid = 1'b1; p_addr = 5'd0; p_data = 64'h1234;
    offer(5'd0);
    chk("l0_ready", l_ready, 1'b1);
    cycle();
    chk("x0_we", we, 1'b0);
    p_valid = 1'b0; l_valid = 1'b0;
    cycle();
    chk("x0_we2", we, 1'b0);

    // fill FIFO while pipe holds the port, then drain in order
    p_valid = 1'b1; p_addr = 5'd1; p_data = 64'h11;
    offer(5'd7);
    cycle();
    offer(5'd8);
    cycle();
    chk("full_ready", l_ready, 1'b0);
    offer(5'd9);
    cycle();
    p_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (acc_last) l_valid = 1'b0;
      if (we) seen.push_back(int'(wr_addr));
    end
    l_valid = 1'b0;
    chk("ord_n", seen.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < seen.size()) chk("ord_addr", seen[i], 7 + i);

    // starvation -> STALL, then drain
    p_valid = 1'b1; p_addr = 5'd1; p_data = 64'h21;
    offer(5'd10);
    cycle();
    l_valid = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      p_addr = 5'(k); p_data = 64'(k);
      cycle();
    end
    chk("stall_pre", stall, 1'b0);
    p_addr = 5'd1;
    cycle();
    chk("stall_on", stall, 1'b1);
    p_valid = 1'b0;
    cycle();
    chk("drain_we", we, 1'b1);
    chk("drain_addr", wr_addr, 5'd10);
    chk("stall_off", stall, 1'b0);

    // reset drops queued entries
    p_valid = 1'b1; p_addr = 5'd2; p_data = 64'h22;
    offer(5'd11);
    cycle();
    offer(5'd13);
    cycle();
    l_valid = 1'b0; p_valid = 1'b0; reset = 1'b1;
    cycle();
    chk("mid_rst_we", we, 1'b0);
    chk("mid_rst_ready", l_ready, 1'b1);
    chk("mid_rst_stall", stall, 1'b0);
    reset = 1'b0;
    cycle();
    chk("post_rst_we", we, 1'b0);

`ifdef RF_WB_PENDING_EN
    p_valid = 1'b1; p_addr = 5'd3; p_data = 64'h33;
    offer(5'd12);
    rd_addr1 = 5'd12; rd_addr2 = 5'd0;
    cycle();
    l_valid = 1'b0;
    chk("pend_q", pend1, 1'b1);
    chk("pend_x0", pend2, 1'b0);
    p_valid = 1'b0;
    cycle();
    chk("pend_out", pend1, 1'b1);
    cycle();
    chk("pend_gone", pend1, 1'b0);
`endif

    // random traffic; source holds an offered result until accepted
    for (int n = 0; n < 400; n++) begin
      reset   = ($urandom_range(0, 99) == 0);
      p_valid = stall ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      p_addr  = 5'($urandom_range(0, 31));
      p_data  = {$urandom, $urandom};
      if (!l_valid || acc_last) begin
        l_valid = ($urandom_range(0, 1) == 1);
        l_addr  = 5'($urandom_range(0, 31));
        l_data  = {$urandom, $urandom};
      end
`ifdef RF_WB_PENDING_EN
      rd_addr1 = 5'($urandom_range(0, 31));
      rd_addr2 = (n % 2 == 0) ? m_addr : 5'($urandom_range(0, 31));
`endif
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
